// File: rtl/caf_lag_sequencer_if.sv
// Address-beat stream toward the reference/capture buffers plus the per-lag
// result strobe coming back from the x_corr bank.
interface caf_lag_sequencer_if #(
    parameter int REF_INDEX_BITS = 5,
    parameter int CAP_INDEX_BITS = 6,
    parameter int LAG_BITS       = 6
);
    logic                      m_axis_addr_tvalid;
    logic                      m_axis_addr_tready;
    logic [REF_INDEX_BITS-1:0] ref_raddr;
    logic [CAP_INDEX_BITS-1:0] cap_raddr;
    logic [LAG_BITS-1:0]       addr_lag;
    logic                      addr_last;
    logic                      s_axis_result_tvalid;

    modport master (
        output m_axis_addr_tvalid, ref_raddr, cap_raddr, addr_lag, addr_last,
        input  m_axis_addr_tready, s_axis_result_tvalid
    );

    modport slave (
        input  m_axis_addr_tvalid, ref_raddr, cap_raddr, addr_lag, addr_last,
        output m_axis_addr_tready, s_axis_result_tvalid
    );
endinterface

// File: rtl/caf_lag_sequencer.sv
// Sequences the CAF correlate sweep: issues paired ref/capture read addresses
// for every lag window, then counts per-lag results and pulses done.
module caf_lag_sequencer #(
    parameter int REF_LEN        = 32,
    parameter int NUM_LAGS       = 33,
    parameter int CAP_LEN        = 64,
    parameter int REF_INDEX_BITS = 5,
    parameter int CAP_INDEX_BITS = 6,
    parameter int LAG_BITS       = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    caf_lag_sequencer_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [REF_INDEX_BITS-1:0] REF_MAX  = REF_INDEX_BITS'(REF_LEN - 1);
    localparam logic [LAG_BITS-1:0]       LAG_MAX  = LAG_BITS'(NUM_LAGS - 1);
    localparam logic [LAG_BITS-1:0]       LAG_FULL = LAG_BITS'(NUM_LAGS);

    // Every lag window must fit inside the capture buffer, so cap_raddr never wraps.
    if (NUM_LAGS < 1 || NUM_LAGS > CAP_LEN - REF_LEN + 1) begin : g_bad_num_lags
        $error("caf_lag_sequencer: NUM_LAGS outside 1..CAP_LEN-REF_LEN+1");
    end

    logic [1:0]                state_q, state_d;
    logic [REF_INDEX_BITS-1:0] ref_q, ref_d;
    logic [LAG_BITS-1:0]       lag_q, lag_d;
    logic [LAG_BITS-1:0]       cnt_q, cnt_d;
    logic [CAP_INDEX_BITS-1:0] cap_q, cap_d;
    logic                      last_q;
    logic                      err_q, err_d;
    logic                      tvalid_q, busy_q, done_q;
    logic                      accept, counting;

    assign accept   = tvalid_q & bus.m_axis_addr_tready;
    assign counting = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        lag_d   = lag_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (counting && bus.s_axis_result_tvalid) begin
            if (cnt_q == LAG_FULL) err_d = 1'b1;
            else                   cnt_d = cnt_q + LAG_BITS'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    ref_d   = '0;
                    lag_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    if (ref_q != REF_MAX) begin
                        ref_d = ref_q + REF_INDEX_BITS'(1);
                    end else begin
                        ref_d = '0;
                        lag_d = lag_q + LAG_BITS'(1);
                        if (lag_q == LAG_MAX) state_d = ST_DRAIN;
                    end
                end
            end
            // Uses the post-update count so done follows the final result by one cycle.
            ST_DRAIN: if (cnt_d == LAG_FULL) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
        endcase

        if (abort_i && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    assign cap_d = CAP_INDEX_BITS'(lag_d) + CAP_INDEX_BITS'(ref_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ref_q    <= '0;
            lag_q    <= '0;
            cap_q    <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            lag_q    <= lag_d;
            cap_q    <= cap_d;
            last_q   <= (ref_d == REF_MAX);
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tvalid_q <= (state_d == ST_ISSUE);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign bus.m_axis_addr_tvalid = tvalid_q;
    assign bus.ref_raddr          = ref_q;
    assign bus.cap_raddr          = cap_q;
    assign bus.addr_lag           = lag_q;
    assign bus.addr_last          = last_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign err_o                  = err_q;
endmodule

// File: tb/tb_caf_lag_sequencer.sv
// Bench for caf_lag_sequencer: a 4x3 sweep instance and a single-beat 1x8 instance
// checked against a beat list built from the sweep rules.
module tb_caf_lag_sequencer;
    localparam int A_REF  = 4;
    localparam int A_LAGS = 3;
    localparam int B_REF  = 1;
    localparam int B_LAGS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0, busy_a, done_a, err_a;
    logic start_b = 1'b0, abort_b = 1'b0, busy_b, done_b, err_b;
    int checks = 0;
    int failures = 0;

    typedef struct {int r; int c; int l; bit last;} beat_t;
    beat_t exp_q[$];

    caf_lag_sequencer_if #(.REF_INDEX_BITS(2), .CAP_INDEX_BITS(3), .LAG_BITS(2)) bus_a();
    caf_lag_sequencer_if #(.REF_INDEX_BITS(1), .CAP_INDEX_BITS(3), .LAG_BITS(4)) bus_b();

    caf_lag_sequencer #(.REF_LEN(A_REF), .NUM_LAGS(A_LAGS), .CAP_LEN(8),
                        .REF_INDEX_BITS(2), .CAP_INDEX_BITS(3), .LAG_BITS(2)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .bus(bus_a));

    caf_lag_sequencer #(.REF_LEN(B_REF), .NUM_LAGS(B_LAGS), .CAP_LEN(8),
                        .REF_INDEX_BITS(1), .CAP_INDEX_BITS(3), .LAG_BITS(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .bus(bus_b));

    always #5 clk = ~clk;

    function automatic logic [7:0] addr_a();
        return {bus_a.ref_raddr, bus_a.cap_raddr, bus_a.addr_lag, bus_a.addr_last};
    endfunction

    function automatic logic [8:0] addr_b();
        return {bus_b.ref_raddr, bus_b.cap_raddr, bus_b.addr_lag, bus_b.addr_last};
    endfunction

    // Beats in issue order: every ref index of lag 0, then lag 1, and so on.
    task automatic build_model(input int ref_len, input int nlags);
        exp_q.delete();
        for (int l = 0; l < nlags; l++)
            for (int r = 0; r < ref_len; r++)
                exp_q.push_back('{r, l + r, l, (r == ref_len - 1)});
    endtask

    function automatic logic [7:0] want_a(input int k);
        return {2'(exp_q[k].r), 3'(exp_q[k].c), 2'(exp_q[k].l), exp_q[k].last};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, err_a, bus_a.m_axis_addr_tvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl_a got=%b want=0000", {busy_a, done_a, err_a, bus_a.m_axis_addr_tvalid});
        end
        checks++;
        if (addr_a() !== 8'h00) begin
            failures++;
            $display("FAIL reset_addr_a got=%h want=00", addr_a());
        end
        checks++;
        if ({busy_b, done_b, err_b, bus_b.m_axis_addr_tvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl_b got=%b want=0000", {busy_b, done_b, err_b, bus_b.m_axis_addr_tvalid});
        end
        checks++;
        if (addr_b() !== 9'h000) begin
            failures++;
            $display("FAIL reset_addr_b got=%h want=000", addr_b());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // mode 0: tready=1; mode 1: tready 1,0,0,1; mode 2: random tready, 2 results in ISSUE, 3rd late.
    task automatic test_sweep(input int mode);
        int k, c, r1, r2, sent;
        build_model(A_REF, A_LAGS);
        r1 = $urandom_range(0, 5);
        r2 = $urandom_range(6, 10);
        sent = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL sweep%0d_busy got=%b want=1", mode, busy_a);
        end
        k = 0;
        c = 0;
        while (k < exp_q.size() && c < 200) begin
            checks++;
            if (bus_a.m_axis_addr_tvalid !== 1'b1 || addr_a() !== want_a(k)) begin
                failures++;
                $display("FAIL sweep%0d_beat%0d got tvalid=%b addr=%h want tvalid=1 addr=%h",
                         mode, k, bus_a.m_axis_addr_tvalid, addr_a(), want_a(k));
            end
            case (mode)
                0:       bus_a.m_axis_addr_tready = 1'b1;
                1:       bus_a.m_axis_addr_tready = (c % 4 == 0) || (c % 4 == 3);
                default: bus_a.m_axis_addr_tready = 1'($urandom_range(0, 1));
            endcase
            bus_a.s_axis_result_tvalid = (mode == 2) && (c == r1 || c == r2);
            if (bus_a.s_axis_result_tvalid) sent++;
            if (bus_a.m_axis_addr_tready) k++;
            c++;
            @(negedge clk);
        end
        bus_a.s_axis_result_tvalid = 1'b0;
        bus_a.m_axis_addr_tready = 1'b0;
        checks++;
        if (k != exp_q.size()) begin
            failures++;
            $display("FAIL sweep%0d_timeout beats=%0d want=%0d", mode, k, exp_q.size());
        end
        checks++;
        if ({bus_a.m_axis_addr_tvalid, busy_a, done_a} !== 3'b010) begin
            failures++;
            $display("FAIL sweep%0d_drain got tvalid,busy,done=%b want=010", mode,
                     {bus_a.m_axis_addr_tvalid, busy_a, done_a});
        end
        if (mode == 2) begin
            repeat (20) @(negedge clk);
            checks++;
            if ({busy_a, done_a} !== 2'b10) begin
                failures++;
                $display("FAIL sweep2_late_wait got busy,done=%b want=10", {busy_a, done_a});
            end
        end
        while (sent < A_LAGS) begin
            bus_a.s_axis_result_tvalid = 1'b1;
            sent++;
            @(negedge clk);
            bus_a.s_axis_result_tvalid = 1'b0;
            checks++;
            if (done_a !== (sent == A_LAGS)) begin
                failures++;
                $display("FAIL sweep%0d_done_after_result%0d got=%b want=%b", mode, sent, done_a, (sent == A_LAGS));
            end
            if (sent < A_LAGS) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, err_a} !== 3'b000) begin
            failures++;
            $display("FAIL sweep%0d_end got busy,done,err=%b want=000", mode, {busy_a, done_a, err_a});
        end
    endtask

    task automatic test_err();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int c = 0; c < A_REF * A_LAGS; c++) begin
            if (c == 7) begin
                checks++;
                if (err_a !== 1'b0) begin
                    failures++;
                    $display("FAIL err_before_extra got=%b want=0", err_a);
                end
            end
            bus_a.m_axis_addr_tready = 1'b1;
            bus_a.s_axis_result_tvalid = (c == 1 || c == 3 || c == 5 || c == 7);
            @(negedge clk);
        end
        bus_a.s_axis_result_tvalid = 1'b0;
        bus_a.m_axis_addr_tready = 1'b0;
        checks++;
        if ({err_a, bus_a.m_axis_addr_tvalid, busy_a, done_a} !== 4'b1010) begin
            failures++;
            $display("FAIL err_drain got err,tvalid,busy,done=%b want=1010",
                     {err_a, bus_a.m_axis_addr_tvalid, busy_a, done_a});
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin
            failures++;
            $display("FAIL err_done got=%b want=1", done_a);
        end
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, err_a} !== 3'b001) begin
            failures++;
            $display("FAIL err_sticky got busy,done,err=%b want=001", {busy_a, done_a, err_a});
        end
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        checks++;
        if ({busy_a, err_a} !== 2'b10) begin
            failures++;
            $display("FAIL err_cleared_by_start got busy,err=%b want=10", {busy_a, err_a});
        end
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        checks++;
        if ({busy_a, bus_a.m_axis_addr_tvalid} !== 2'b00) begin
            failures++;
            $display("FAIL err_abort got busy,tvalid=%b want=00", {busy_a, bus_a.m_axis_addr_tvalid});
        end
    endtask

    task automatic test_abort();
        logic bad;
        build_model(A_REF, A_LAGS);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus_a.m_axis_addr_tready = 1'b1;
            bus_a.s_axis_result_tvalid = (c == 1 || c == 3);
            @(negedge clk);
        end
        bus_a.s_axis_result_tvalid = 1'b0;
        checks++;
        if (bus_a.m_axis_addr_tvalid !== 1'b1 || addr_a() !== want_a(6)) begin
            failures++;
            $display("FAIL abort_beat6 got tvalid=%b addr=%h want tvalid=1 addr=%h",
                     bus_a.m_axis_addr_tvalid, addr_a(), want_a(6));
        end
        abort_a = 1'b1;
        bus_a.m_axis_addr_tready = 1'b0;
        @(negedge clk); abort_a = 1'b0;
        checks++;
        if ({bus_a.m_axis_addr_tvalid, busy_a, done_a} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle got tvalid,busy,done=%b want=000",
                     {bus_a.m_axis_addr_tvalid, busy_a, done_a});
        end
        bad = 1'b0;
        bus_a.s_axis_result_tvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus_a.s_axis_result_tvalid = 1'b0;
            if (done_a !== 1'b0 || busy_a !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got glitch=%b want=0", bad);
        end
    endtask

    task automatic test_async_reset();
        build_model(A_REF, A_LAGS);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (bus_a.m_axis_addr_tvalid !== 1'b1 || addr_a() !== want_a(c)) begin
                failures++;
                $display("FAIL areset_beat%0d got tvalid=%b addr=%h want tvalid=1 addr=%h",
                         c, bus_a.m_axis_addr_tvalid, addr_a(), want_a(c));
            end
            bus_a.m_axis_addr_tready = 1'b1;
            start_a = (c == 3);
            @(negedge clk);
        end
        start_a = 1'b0;
        checks++;
        if (bus_a.m_axis_addr_tvalid !== 1'b1 || addr_a() !== want_a(8)) begin
            failures++;
            $display("FAIL areset_beat8 got tvalid=%b addr=%h want tvalid=1 addr=%h",
                     bus_a.m_axis_addr_tvalid, addr_a(), want_a(8));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, err_a, bus_a.m_axis_addr_tvalid} !== 4'b0000 || addr_a() !== 8'h00) begin
            failures++;
            $display("FAIL areset_immediate got ctrl=%b addr=%h want ctrl=0000 addr=00",
                     {busy_a, done_a, err_a, bus_a.m_axis_addr_tvalid}, addr_a());
        end
        bus_a.m_axis_addr_tready = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, bus_a.m_axis_addr_tvalid} !== 3'b000) begin
            failures++;
            $display("FAIL areset_release got busy,done,tvalid=%b want=000",
                     {busy_a, done_a, bus_a.m_axis_addr_tvalid});
        end
    endtask

    task automatic test_single_beat();
        int k, c;
        logic [8:0] want;
        build_model(B_REF, B_LAGS);
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        k = 0;
        c = 0;
        while (k < exp_q.size() && c < 100) begin
            want = {1'(exp_q[k].r), 3'(exp_q[k].c), 4'(exp_q[k].l), exp_q[k].last};
            checks++;
            if (bus_b.m_axis_addr_tvalid !== 1'b1 || addr_b() !== want) begin
                failures++;
                $display("FAIL single_beat%0d got tvalid=%b addr=%h want tvalid=1 addr=%h",
                         k, bus_b.m_axis_addr_tvalid, addr_b(), want);
            end
            bus_b.m_axis_addr_tready = 1'($urandom_range(0, 1));
            if (bus_b.m_axis_addr_tready) k++;
            c++;
            @(negedge clk);
        end
        bus_b.m_axis_addr_tready = 1'b0;
        checks++;
        if (k != exp_q.size() || bus_b.m_axis_addr_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_issue_end got beats=%0d tvalid=%b want beats=%0d tvalid=0",
                     k, bus_b.m_axis_addr_tvalid, exp_q.size());
        end
        for (int n = 1; n <= B_LAGS; n++) begin
            bus_b.s_axis_result_tvalid = 1'b1;
            @(negedge clk);
            bus_b.s_axis_result_tvalid = 1'b0;
            checks++;
            if (done_b !== (n == B_LAGS)) begin
                failures++;
                $display("FAIL single_done_after_result%0d got=%b want=%b", n, done_b, (n == B_LAGS));
            end
            if (n < B_LAGS) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if ({busy_b, done_b, err_b} !== 3'b000) begin
            failures++;
            $display("FAIL single_end got busy,done,err=%b want=000", {busy_b, done_b, err_b});
        end
    endtask

    initial begin
        bus_a.m_axis_addr_tready   = 1'b0;
        bus_a.s_axis_result_tvalid = 1'b0;
        bus_b.m_axis_addr_tready   = 1'b0;
        bus_b.s_axis_result_tvalid = 1'b0;
        test_reset();
        test_sweep(0);
        test_sweep(1);
        test_sweep(2);
        test_err();
        test_abort();
        test_sweep(0);
        test_async_reset();
        test_single_beat();
        test_sweep(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
